pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed 70-bit enable-gated pipeline register.
- Carries a WIDTH-bit payload with a valid/ready handshake between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Supports synchronous flush with bubble insertion, an optional 2-entry skid mode that registers the upstream ready, and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_data_reg.sv | 28 ++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: occupancy states,
// default widths and the NOP bubble payload.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_WIDTH = 70;
    localparam int PIPE_CNT_W = 16;

    localparam logic [PIPE_CNT_W-1:0] PIPE_CNT_SAT = {PIPE_CNT_W{1'b1}};

    // NOP encoding loaded into every stage on reset and flush.
    localparam logic [PIPE_WIDTH-1:0] PIPE_NOP = {PIPE_WIDTH{1'b0}};

endpackage

// File: rtl/pipe_data_reg.sv
// One payload entry of a pipeline stage: load-enabled register that returns
// to the bubble value on reset.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] RST_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RST_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry, synchronous
// flush to bubble, and a saturating backpressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH        = PIPE_WIDTH,
    parameter int               SKID         = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W        = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    logic             w_accept;
    logic             w_drain;
    logic             w_main_en;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_skid_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;
    logic [CNT_W-1:0] r_stall_cnt;

    assign out_valid   = (r_state != PS_EMPTY);
    assign out_data    = w_main_q;
    assign stall_count = r_stall_cnt;
    assign w_accept    = in_valid & in_ready;
    assign w_drain     = out_valid & out_ready;

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RST_VALUE (BUBBLE_VALUE)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_main_en),
        .i_d  (w_main_d),
        .o_q  (w_main_q)
    );

    // With a skid entry, in_ready is a pure decode of the state flop so the
    // upstream never sees a combinational path from out_ready.
    generate
        if (SKID != 0) begin : g_skid
            pipe_data_reg #(
                .WIDTH     (WIDTH),
                .RST_VALUE (BUBBLE_VALUE)
            ) u_skid (
                .clk  (clk),
                .rst  (rst),
                .i_en (w_skid_en),
                .i_d  (w_skid_d),
                .o_q  (w_skid_q)
            );
            assign in_ready = (r_state != PS_TWO);
        end else begin : g_noskid
            assign w_skid_q = BUBBLE_VALUE;
            assign in_ready = (r_state == PS_EMPTY) | out_ready;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_main_en   = 1'b0;
        w_main_d    = in_data;
        w_skid_en   = 1'b0;
        w_skid_d    = in_data;
        if (flush) begin
            w_state_nxt = PS_EMPTY;
            w_main_en   = 1'b1;
            w_main_d    = BUBBLE_VALUE;
            w_skid_en   = 1'b1;
            w_skid_d    = BUBBLE_VALUE;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = PS_ONE;
                        w_main_en   = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_en = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = PS_TWO;
                        w_skid_en   = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    if (w_drain) begin
                        w_state_nxt = PS_ONE;
                        w_main_en   = 1'b1;
                        w_main_d    = w_skid_q;
                        w_skid_en   = 1'b1;
                        w_skid_d    = BUBBLE_VALUE;
                    end
                end
                default: w_state_nxt = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PS_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Backpressure counter keeps counting across flushes; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus and
// are each compared every cycle against a small FIFO reference model.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        ir1, ov1, ir0, ov0;
    logic [15:0] od1, od0;
    logic [3:0]  sc1, sc0;

    int checks   = 0;
    int failures = 0;

    // Reference model: per instance, a FIFO of accepted payloads (depth 2 or 1).
    int          mn [2];
    logic [15:0] mb [2][2];
    int          ms [2];

    pipe_stage_reg #(
        .WIDTH(16), .SKID(1), .BUBBLE_VALUE(16'h0000), .CNT_W(4)
    ) u_s1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .stall_count(sc1)
    );

    pipe_stage_reg #(
        .WIDTH(16), .SKID(0), .BUBBLE_VALUE(16'h0000), .CNT_W(4)
    ) u_s0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .stall_count(sc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int s);
        if (s == 1) return (mn[1] < 2);
        return (mn[0] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mn[s] = 0;
            ms[s] = 0;
        end
    endtask

    task automatic model_step();
        bit rdy, acc, drn;
        for (int s = 0; s < 2; s++) begin
            rdy = m_ready(s);
            acc = in_valid && rdy;
            drn = (mn[s] > 0) && out_ready;
            if (mn[s] > 0 && !out_ready && ms[s] < 15) ms[s]++;
            if (flush) begin
                mn[s] = 0;
            end else begin
                if (drn) begin
                    mb[s][0] = mb[s][1];
                    mn[s]--;
                end
                if (acc) begin
                    mb[s][mn[s]] = in_data;
                    mn[s]++;
                end
            end
        end
    endtask

    task automatic check_inst(input int s, input logic v, input logic [15:0] d,
                              input logic r, input logic [3:0] c);
        chk($sformatf("skid%0d_out_valid", s), 32'(v), 32'(mn[s] != 0));
        if (mn[s] != 0) chk($sformatf("skid%0d_out_data", s), 32'(d), 32'(mb[s][0]));
        chk($sformatf("skid%0d_in_ready", s), 32'(r), 32'(m_ready(s)));
        chk($sformatf("skid%0d_stall_count", s), 32'(c), 32'(ms[s]));
    endtask

    // Inputs are set at the falling edge; outputs are compared 1 ns later.
    task automatic cyc();
        #1;
        check_inst(1, ov1, od1, ir1, sc1);
        check_inst(0, ov0, od0, ir0, sc0);
        if (!rst) model_reset();
        else      model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        model_reset();
        #1;
        chk("reset_out_valid", 32'(ov1), 32'd0);
        chk("reset_out_data",  32'(od1), 32'h0);
        chk("reset_in_ready",  32'(ir1), 32'd1);
        chk("reset_stall",     32'(sc1), 32'd0);
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b1;

        // Streaming with no backpressure.
        for (int v = 1; v <= 5; v++) begin
            drive(1'b1, 16'(v), 1'b1);
            cyc();
        end
        drive(1'b0, 16'h0, 1'b1);
        #1 chk("stream_last", 32'(od1), 32'h5);
        cyc(); cyc();

        // Backpressure into the skid entry.
        drive(1'b1, 16'hA1, 1'b1); cyc();
        drive(1'b1, 16'hA2, 1'b0); cyc();
        drive(1'b1, 16'hA3, 1'b0);
        #1;
        chk("bp_hold_a1",   32'(od1), 32'hA1);
        chk("bp_in_ready0", 32'(ir1), 32'd0);
        cyc(); cyc(); cyc();
        drive(1'b1, 16'hA3, 1'b1);
        #1 chk("bp_stall_cnt", 32'(sc1), 32'd4);
        cyc(); cyc();
        drive(1'b0, 16'h0, 1'b1);
        cyc(); cyc();

        // Flush while both entries are occupied, with a transfer offered.
        drive(1'b1, 16'hB1, 1'b0); cyc();
        drive(1'b1, 16'hB2, 1'b0); cyc();
        drive(1'b1, 16'hB3, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 16'h0, 1'b1);
        #1;
        chk("flush_out_valid", 32'(ov1), 32'd0);
        chk("flush_out_data",  32'(od1), 32'h0);
        chk("flush_in_ready",  32'(ir1), 32'd1);
        chk("flush_out_data0", 32'(od0), 32'h0);
        cyc(); cyc(); cyc();

        // Stall counter saturation, then SKID=0 combinational ready.
        drive(1'b1, 16'hC0, 1'b1); cyc();
        drive(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) cyc();
        #1;
        chk("sat_stall1",    32'(sc1), 32'hF);
        chk("sat_stall0",    32'(sc0), 32'hF);
        chk("noskid_ready0", 32'(ir0), 32'd0);
        drive(1'b1, 16'hC1, 1'b1);
        #1 chk("noskid_ready1", 32'(ir0), 32'd1);
        cyc();
        drive(1'b0, 16'h0, 1'b1);
        #1 chk("noskid_pass_c1", 32'(od0), 32'hC1);
        cyc(); cyc();

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 15) == 0);
            cyc();
        end
        flush = 1'b0;

        // Asynchronous reset between clock edges while both entries are full.
        drive(1'b0, 16'h0, 1'b1); cyc(); cyc();
        drive(1'b1, 16'hD1, 1'b0); cyc();
        drive(1'b1, 16'hD2, 1'b0); cyc();
        drive(1'b0, 16'h0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("areset_out_valid", 32'(ov1), 32'd0);
        chk("areset_out_data",  32'(od1), 32'h0);
        chk("areset_stall",     32'(sc1), 32'd0);
        chk("areset_in_ready",  32'(ir1), 32'd1);
        model_reset();
        cyc();
        rst = 1'b1;
        for (int v = 16'hE1; v <= 16'hE4; v++) begin
            drive(1'b1, 16'(v), 1'b1);
            cyc();
        end
        drive(1'b0, 16'h0, 1'b1);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
